lfsr_period_checker: RTL and testbench

//  Downstream consumer of the 4-bit LFSR output word. Captures the first word

---
 rtl/lfsr_period_checker_pkg.sv | 18 +
 rtl/lfsr_period_checker_seen_bitmap.sv | 39 +++
 rtl/lfsr_period_checker.sv | 136 +++++++++++++
 tb/tb_lfsr_period_checker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_period_checker_pkg.sv
// Shared state encoding and width constants for the LFSR period checker.
package lfsr_period_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 4;
    localparam int MAXLEN    = (1 << WIDTH_DEF) - 1;

    // Period of a maximal-length LFSR of the given word width.
    function automatic int maxlen_of(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/lfsr_period_checker_seen_bitmap.sv
// One flag per possible LFSR word; records which words were seen in the current run.
module lfsr_period_checker_seen_bitmap
    import lfsr_period_checker_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             set_i,
    input  logic [WIDTH-1:0] set_idx_i,
    input  logic [WIDTH-1:0] rd_idx_i,
    output logic             rd_o
);

    localparam int DEPTH = 1 << WIDTH;

    logic [DEPTH-1:0] bits_q;
    logic [DEPTH-1:0] bits_d;

    // Clear and set in the same cycle leaves exactly the new word flagged.
    always_comb begin
        bits_d = clr_i ? '0 : bits_q;
        if (set_i) begin
            bits_d[set_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign rd_o = bits_q[rd_idx_i];

endmodule

// File: rtl/lfsr_period_checker.sv
// Measures the recurrence period of an LFSR word stream and flags lock-up,
// maximal-length runs and sub-cycles that never return to the first word.
module lfsr_period_checker
    import lfsr_period_checker_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   period,
    output logic             max_len,
    output logic             lockup,
    output logic             sub_err
);

    localparam logic [WIDTH:0] MAX_CNT = (WIDTH + 1)'(maxlen_of(WIDTH));

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH:0]   count_q, count_d;
    logic [WIDTH:0]   period_q, period_d;
    logic             max_len_q, max_len_d;
    logic             lockup_q, lockup_d;
    logic             sub_err_q, sub_err_d;

    logic             seen_clr;
    logic             seen_set;
    logic             seen_rd;
    logic             capture;
    logic             word_zero;

    lfsr_period_checker_seen_bitmap #(
        .WIDTH (WIDTH)
    ) u_seen (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (seen_clr),
        .set_i     (seen_set),
        .set_idx_i (data_in),
        .rd_idx_i  (data_in),
        .rd_o      (seen_rd)
    );

    assign word_zero = (data_in == '0);
    assign capture   = start && en && (state_q != ST_RUN);

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        count_d   = count_q;
        period_d  = period_q;
        max_len_d = max_len_q;
        lockup_d  = lockup_q;
        sub_err_d = sub_err_q;
        seen_clr  = 1'b0;
        seen_set  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Restarting from DONE wipes the previous result before capturing.
                if (capture) begin
                    period_d  = '0;
                    max_len_d = 1'b0;
                    lockup_d  = 1'b0;
                    sub_err_d = 1'b0;
                    seen_clr  = 1'b1;
                    if (word_zero) begin
                        lockup_d = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        ref_d    = data_in;
                        seen_set = 1'b1;
                        count_d  = (WIDTH + 1)'(1);
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (en) begin
                    if (word_zero) begin
                        lockup_d = 1'b1;
                        period_d = '0;
                        state_d  = ST_DONE;
                    end else if (data_in == ref_q) begin
                        period_d  = count_q;
                        max_len_d = (count_q == MAX_CNT);
                        state_d   = ST_DONE;
                    end else if (seen_rd) begin
                        sub_err_d = 1'b1;
                        period_d  = '0;
                        state_d   = ST_DONE;
                    end else begin
                        seen_set = 1'b1;
                        count_d  = count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ref_q     <= '0;
            count_q   <= '0;
            period_q  <= '0;
            max_len_q <= 1'b0;
            lockup_q  <= 1'b0;
            sub_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            count_q   <= count_d;
            period_q  <= period_d;
            max_len_q <= max_len_d;
            lockup_q  <= lockup_d;
            sub_err_q <= sub_err_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign period  = period_q;
    assign max_len = max_len_q;
    assign lockup  = lockup_q;
    assign sub_err = sub_err_q;

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Directed bench for lfsr_period_checker: LFSR run, short cycle, sub-cycle, lock-up, en gaps, reset abort.
module tb_lfsr_period_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       en;
    logic [3:0] data_in;
    logic       busy;
    logic       done;
    logic [4:0] period;
    logic       max_len;
    logic       lockup;
    logic       sub_err;

    int n_checks;
    int n_fail;

    logic [3:0] lfsr_seq [16] = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
                                  4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h8};

    lfsr_period_checker #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .en      (en),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .period  (period),
        .max_len (max_len),
        .lockup  (lockup),
        .sub_err (sub_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: drive inputs, let one posedge pass, return at the next negedge.
    task automatic step(input logic s, input logic e, input logic [3:0] d);
        start   = s;
        en      = e;
        data_in = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1; en = 1'b1; data_in = 4'h5;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, period, max_len, lockup, sub_err} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {busy, done, period, max_len, lockup, sub_err});
        end
        rst = 1'b0;
        step(1'b1, 1'b0, 4'h5);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_without_en: got busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic run_lfsr(input string tag);
        step(1'b1, 1'b1, lfsr_seq[0]);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_after_capture: got busy=%b done=%b want 1 0", tag, busy, done);
        end
        for (int i = 1; i < 15; i++) step(1'b0, 1'b1, lfsr_seq[i]);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_not_done_early: got busy=%b done=%b want 1 0", tag, busy, done);
        end
        step(1'b0, 1'b1, lfsr_seq[15]);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || period !== 5'd15 || max_len !== 1'b1
            || lockup !== 1'b0 || sub_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_result: got done=%b period=%0d max_len=%b lockup=%b sub_err=%b want 1 15 1 0 0",
                     tag, done, period, max_len, lockup, sub_err);
        end
    endtask

    task automatic test_maxlen;
        run_lfsr("maxlen");
        step(1'b0, 1'b1, 4'h4);
        n_checks++;
        if (done !== 1'b1 || period !== 5'd15 || max_len !== 1'b1) begin
            n_fail++;
            $display("FAIL maxlen_hold: got done=%b period=%0d max_len=%b want 1 15 1", done, period, max_len);
        end
    endtask

    task automatic test_short_cycle;
        step(1'b1, 1'b1, 4'h3);
        step(1'b1, 1'b1, 4'h5);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL short_start_ignored_in_run: got busy=%b done=%b want 1 0", busy, done);
        end
        step(1'b0, 1'b1, 4'h3);
        n_checks++;
        if (done !== 1'b1 || period !== 5'd2 || max_len !== 1'b0 || lockup !== 1'b0 || sub_err !== 1'b0) begin
            n_fail++;
            $display("FAIL short_result: got done=%b period=%0d max_len=%b lockup=%b sub_err=%b want 1 2 0 0 0",
                     done, period, max_len, lockup, sub_err);
        end
    endtask

    task automatic test_sub_cycle;
        step(1'b1, 1'b1, 4'h1);
        step(1'b0, 1'b1, 4'h2);
        step(1'b0, 1'b1, 4'h3);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_still_running: got busy=%b want 1", busy);
        end
        step(1'b0, 1'b1, 4'h2);
        n_checks++;
        if (done !== 1'b1 || sub_err !== 1'b1 || period !== 5'd0 || lockup !== 1'b0 || max_len !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_result: got done=%b sub_err=%b period=%0d lockup=%b max_len=%b want 1 1 0 0 0",
                     done, sub_err, period, lockup, max_len);
        end
    endtask

    task automatic test_lockup;
        step(1'b1, 1'b1, 4'h0);
        n_checks++;
        if (done !== 1'b1 || lockup !== 1'b1 || period !== 5'd0 || sub_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lockup_idle: got done=%b lockup=%b period=%0d sub_err=%b busy=%b want 1 1 0 0 0",
                     done, lockup, period, sub_err, busy);
        end
        step(1'b1, 1'b1, 4'h6);
        n_checks++;
        if (busy !== 1'b1 || lockup !== 1'b0) begin
            n_fail++;
            $display("FAIL lockup_rearm: got busy=%b lockup=%b want 1 0", busy, lockup);
        end
        step(1'b0, 1'b1, 4'h0);
        n_checks++;
        if (done !== 1'b1 || lockup !== 1'b1 || period !== 5'd0) begin
            n_fail++;
            $display("FAIL lockup_run: got done=%b lockup=%b period=%0d want 1 1 0", done, lockup, period);
        end
    endtask

    task automatic test_en_gaps;
        step(1'b1, 1'b1, 4'h3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h3);
        step(1'b0, 1'b1, 4'h5);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h5);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_frozen: got busy=%b done=%b want 1 0", busy, done);
        end
        step(1'b0, 1'b1, 4'h3);
        n_checks++;
        if (done !== 1'b1 || period !== 5'd2 || sub_err !== 1'b0 || max_len !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_result: got done=%b period=%0d sub_err=%b max_len=%b want 1 2 0 0",
                     done, period, sub_err, max_len);
        end
    endtask

    task automatic test_reset_mid_run;
        step(1'b1, 1'b1, 4'h8);
        step(1'b0, 1'b1, 4'h4);
        step(1'b0, 1'b1, 4'h2);
        step(1'b0, 1'b1, 4'h9);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, period, max_len, lockup, sub_err} !== 10'b0) begin
            n_fail++;
            $display("FAIL midrun_reset_async: got %b want 0", {busy, done, period, max_len, lockup, sub_err});
        end
        start = 1'b1; en = 1'b1; data_in = 4'hC;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, period, max_len, lockup, sub_err} !== 10'b0) begin
            n_fail++;
            $display("FAIL midrun_reset_held: got %b want 0", {busy, done, period, max_len, lockup, sub_err});
        end
        rst = 1'b0;
        run_lfsr("after_reset");
        step(1'b1, 1'b1, 4'h8);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || period !== 5'd0 || max_len !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_rearm: got busy=%b done=%b period=%0d max_len=%b want 1 0 0 0",
                     busy, done, period, max_len);
        end
        for (int i = 1; i < 16; i++) step(1'b0, 1'b1, lfsr_seq[i]);
        n_checks++;
        if (done !== 1'b1 || period !== 5'd15 || max_len !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_result: got done=%b period=%0d max_len=%b want 1 15 1",
                     done, period, max_len);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; en = 1'b0; data_in = 4'h0;
        test_reset();
        test_maxlen();
        test_short_cycle();
        test_sub_cycle();
        test_lockup();
        test_en_gaps();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
